oled_sched: RTL and testbench

OLED_SCHED -- requirements
Module: oled_sched

---
 rtl/oled_sched.sv | 180 ++++++++++++++++++
 tb/tb_oled_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_sched.sv
// Scheduler in front of an OLED controller: arbitrates two character requesters,
// batches display updates and sequences power-on/off with a sticky watchdog.
module oled_sched #(
   parameter int AUTO_UPD = 8,
   parameter int TMO_W    = 24
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic       a_valid,
   input  logic [7:0] a_ascii,
   input  logic [5:0] a_pos,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [7:0] b_ascii,
   input  logic [5:0] b_pos,
   output logic       b_ready,
   input  logic       flush,
   input  logic       clear,
   output logic       disp_up,
   output logic       busy,
   output logic       err,
   output logic       write_start,
   output logic [7:0] write_ascii_data,
   output logic [8:0] write_base_addr,
   input  logic       write_ready,
   output logic       update_start,
   output logic       update_clear,
   input  logic       update_ready,
   output logic       disp_on_start,
   input  logic       disp_on_ready,
   output logic       disp_off_start,
   input  logic       disp_off_ready
);

   typedef enum logic [2:0] {
      S_OFF, S_ON_WAIT, S_IDLE, S_WR_WAIT, S_UPD_WAIT, S_OFF_WAIT
   } state_t;

   localparam logic [6:0]       AUTO_THR = 7'(AUTO_UPD);
   localparam logic [TMO_W-1:0] WD_MAX   = '1;
   localparam logic [TMO_W-1:0] WD_ONE   = 1;

   state_t           state, state_nx;
   logic [6:0]       dirty, dirty_nx;
   logic [TMO_W-1:0] wdog, wdog_nx;
   logic             fl_pend, fl_pend_nx, clr_pend, clr_pend_nx;
   logic             last_a, last_a_nx;
   logic             ws_nx, us_nx, uc_nx, on_nx, off_nx, ar_nx, br_nx;
   logic [7:0]       data_nx;
   logic [8:0]       addr_nx;
   logic             first, grant_a, grant_b, in_wait, drop;
   logic             fl_take, clr_take, entry_clr;

   // A start pulse is visible exactly in the first cycle of its wait state.
   assign first   = write_start | update_start | disp_on_start | disp_off_start;
   assign grant_a = a_valid && (!b_valid || !last_a);
   assign grant_b = b_valid && !grant_a;
   assign in_wait = (state != S_OFF) && (state != S_IDLE);
   assign drop    = (state == S_OFF) || (state == S_ON_WAIT);
   assign disp_up = (state == S_IDLE) || (state == S_WR_WAIT) || (state == S_UPD_WAIT);
   assign busy    = in_wait;

   always_comb begin
      state_nx  = state;
      ws_nx     = 1'b0;
      us_nx     = 1'b0;
      uc_nx     = update_clear;
      on_nx     = 1'b0;
      off_nx    = 1'b0;
      ar_nx     = 1'b0;
      br_nx     = 1'b0;
      data_nx   = write_ascii_data;
      addr_nx   = write_base_addr;
      dirty_nx  = dirty;
      last_a_nx = last_a;
      fl_take   = 1'b0;
      clr_take  = 1'b0;
      entry_clr = 1'b0;
      case (state)
         S_OFF: begin
            if (en && update_ready) begin
               state_nx  = S_IDLE;
               entry_clr = 1'b1;
            end else if (en && disp_on_ready) begin
               on_nx    = 1'b1;
               state_nx = S_ON_WAIT;
            end
         end
         S_ON_WAIT: begin
            if (!first && update_ready) begin
               state_nx  = S_IDLE;
               entry_clr = 1'b1;
            end
         end
         S_IDLE: begin
            // A blocked higher-priority action waits rather than falling through.
            if (!en) begin
               if (disp_off_ready) begin
                  off_nx   = 1'b1;
                  state_nx = S_OFF_WAIT;
               end
            end else if (clr_pend) begin
               if (update_ready) begin
                  us_nx    = 1'b1;
                  uc_nx    = 1'b1;
                  clr_take = 1'b1;
                  state_nx = S_UPD_WAIT;
               end
            end else if (fl_pend || (dirty >= AUTO_THR)) begin
               if (update_ready) begin
                  us_nx    = 1'b1;
                  uc_nx    = 1'b0;
                  fl_take  = 1'b1;
                  dirty_nx = 7'd0;
                  state_nx = S_UPD_WAIT;
               end
            end else if ((a_valid || b_valid) && write_ready) begin
               ws_nx     = 1'b1;
               ar_nx     = grant_a;
               br_nx     = grant_b;
               data_nx   = grant_a ? a_ascii : b_ascii;
               addr_nx   = {grant_a ? a_pos : b_pos, 3'b000};
               last_a_nx = grant_a;
               dirty_nx  = (dirty == 7'h7F) ? dirty : dirty + 7'd1;
               state_nx  = S_WR_WAIT;
            end
         end
         S_WR_WAIT:  if (!first && write_ready)   state_nx = S_IDLE;
         S_UPD_WAIT: if (!first && update_ready)  state_nx = S_IDLE;
         S_OFF_WAIT: if (!first && disp_on_ready) state_nx = S_OFF;
         default:    state_nx = S_OFF;
      endcase
      if (entry_clr) dirty_nx = 7'd0;
      fl_pend_nx  = !entry_clr && ((fl_pend && !fl_take) || (flush && !drop));
      clr_pend_nx = !entry_clr && ((clr_pend && !clr_take) || (clear && !drop));
      if ((state_nx != state) || !in_wait) wdog_nx = '0;
      else if (wdog == WD_MAX)             wdog_nx = wdog;
      else                                 wdog_nx = wdog + WD_ONE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= S_OFF;
         write_start      <= 1'b0;
         update_start     <= 1'b0;
         update_clear     <= 1'b0;
         disp_on_start    <= 1'b0;
         disp_off_start   <= 1'b0;
         a_ready          <= 1'b0;
         b_ready          <= 1'b0;
         write_ascii_data <= 8'd0;
         write_base_addr  <= 9'd0;
         dirty            <= 7'd0;
         fl_pend          <= 1'b0;
         clr_pend         <= 1'b0;
         last_a           <= 1'b0;
         wdog             <= '0;
         err              <= 1'b0;
      end else begin
         state            <= state_nx;
         write_start      <= ws_nx;
         update_start     <= us_nx;
         update_clear     <= uc_nx;
         disp_on_start    <= on_nx;
         disp_off_start   <= off_nx;
         a_ready          <= ar_nx;
         b_ready          <= br_nx;
         write_ascii_data <= data_nx;
         write_base_addr  <= addr_nx;
         dirty            <= dirty_nx;
         fl_pend          <= fl_pend_nx;
         clr_pend         <= clr_pend_nx;
         last_a           <= last_a_nx;
         wdog             <= wdog_nx;
         err              <= err | (wdog_nx == WD_MAX);
      end
   end

endmodule

// File: tb/tb_oled_sched.sv
// Directed bench for oled_sched: a per-cycle control vector table plus
// hand-written sequences for arbitration, auto update, power-down and watchdog.
module tb_oled_sched;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       en = 1'b0, a_valid = 1'b0, b_valid = 1'b0, flush = 1'b0, clear = 1'b0;
   logic [7:0] a_ascii = 8'h00, b_ascii = 8'h00;
   logic [5:0] a_pos = 6'h00, b_pos = 6'h00;
   logic       write_ready = 1'b0, update_ready = 1'b0, disp_on_ready = 1'b0, disp_off_ready = 1'b0;
   logic       a_ready, b_ready, disp_up, busy, err;
   logic       write_start, update_start, update_clear, disp_on_start, disp_off_start;
   logic [7:0] write_ascii_data;
   logic [8:0] write_base_addr;

   always #5 clk = ~clk;

   oled_sched #(.AUTO_UPD(8), .TMO_W(4)) dut (
      .clk(clk), .rstn(rstn), .en(en),
      .a_valid(a_valid), .a_ascii(a_ascii), .a_pos(a_pos), .a_ready(a_ready),
      .b_valid(b_valid), .b_ascii(b_ascii), .b_pos(b_pos), .b_ready(b_ready),
      .flush(flush), .clear(clear), .disp_up(disp_up), .busy(busy), .err(err),
      .write_start(write_start), .write_ascii_data(write_ascii_data),
      .write_base_addr(write_base_addr), .write_ready(write_ready),
      .update_start(update_start), .update_clear(update_clear), .update_ready(update_ready),
      .disp_on_start(disp_on_start), .disp_on_ready(disp_on_ready),
      .disp_off_start(disp_off_start), .disp_off_ready(disp_off_ready)
   );

   typedef struct packed {
      logic [8:0] stim;   // {en,a_valid,b_valid,flush,clear,write_ready,update_ready,disp_on_ready,disp_off_ready}
      logic [9:0] resp;   // {write_start,a_ready,b_ready,update_start,update_clear,disp_on_start,disp_off_start,disp_up,busy,err}
   } vec_t;

   vec_t tbl [28];
   int   errs = 0;
   int   checks = 0;
   int   multi = 0;
   int   act_kind [32];
   logic act_uc [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] outv();
      return {write_start, a_ready, b_ready, update_start, update_clear,
              disp_on_start, disp_off_start, disp_up, busy, err};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if ($countones({write_start, update_start, disp_on_start, disp_off_start}) > 1) multi++;
   endtask

   task automatic rec(input int n, input int bound, output int got);
      got = 0;
      for (int c = 0; c < bound && got < n; c++) begin
         step();
         if (write_start) begin
            act_kind[got] = 0;
            act_uc[got]   = 1'b0;
            got++;
         end else if (update_start) begin
            act_kind[got] = 1;
            act_uc[got]   = update_clear;
            got++;
         end
      end
   endtask

   task automatic wait_ws(input string name);
      int found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         step();
         if (write_start) found = 1;
      end
      chk(name, 32'(found), 32'd1);
   endtask

   task automatic reset_on();
      rstn = 1'b0;
      #1;
      step();
      rstn = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int got, g, stray, cnt;
      tbl[0]  = {9'b100001011, 10'b0000010010};
      tbl[1]  = {9'b100001001, 10'b0000000010};
      tbl[2]  = {9'b100001101, 10'b0000000100};
      tbl[3]  = {9'b110001101, 10'b1100000110};
      tbl[4]  = {9'b100000101, 10'b0000000110};
      tbl[5]  = {9'b100001101, 10'b0000000100};
      tbl[6]  = {9'b100101101, 10'b0000000100};
      tbl[7]  = {9'b100001101, 10'b0001000110};
      tbl[8]  = {9'b100001001, 10'b0000000110};
      tbl[9]  = {9'b100001101, 10'b0000000100};
      tbl[10] = {9'b100011101, 10'b0000000100};
      tbl[11] = {9'b100001101, 10'b0001100110};
      tbl[12] = {9'b100001101, 10'b0000100110};
      tbl[13] = {9'b100001101, 10'b0000100100};
      tbl[14] = {9'b000001101, 10'b0000101010};
      tbl[15] = {9'b000001101, 10'b0000100010};
      tbl[16] = {9'b000001111, 10'b0000100000};
      tbl[17] = {9'b000101111, 10'b0000100000};
      tbl[18] = {9'b100001111, 10'b0000100100};
      tbl[19] = {9'b100001101, 10'b0000100100};
      tbl[20] = {9'b100101101, 10'b0000100100};
      tbl[21] = {9'b100101101, 10'b0001000110};
      tbl[22] = {9'b100001001, 10'b0000000110};
      tbl[23] = {9'b100001101, 10'b0000000100};
      tbl[24] = {9'b100001101, 10'b0001000110};
      tbl[25] = {9'b100001101, 10'b0000000110};
      tbl[26] = {9'b100001101, 10'b0000000100};
      tbl[27] = {9'b100001101, 10'b0000000100};

      step();
      step();
      chk("reset_outs", 32'(outv()), 32'd0);
      chk("reset_data", 32'({write_ascii_data, write_base_addr}), 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < 28; i++) begin
         {en, a_valid, b_valid, flush, clear, write_ready, update_ready,
          disp_on_ready, disp_off_ready} = tbl[i].stim;
         if (i == 3) begin
            a_ascii = 8'h55;
            a_pos   = 6'h25;
         end
         step();
         chk($sformatf("vec%0d", i), 32'(outv()), 32'(tbl[i].resp));
      end
      chk("held_ascii", 32'(write_ascii_data), 32'h55);
      chk("held_addr", 32'(write_base_addr), 32'h128);

      // reset in the middle of a write, downstream left powered
      a_valid = 1'b1;
      wait_ws("midop_ws");
      rstn = 1'b0;
      #1;
      chk("async_rst_outs", 32'(outv()), 32'd0);
      chk("async_rst_data", 32'({write_ascii_data, write_base_addr}), 32'd0);
      a_valid = 1'b0;
      step();
      rstn = 1'b1;
      step();
      chk("recover_on", 32'(outv()), 32'b0000000100);

      // round-robin with both requesters always valid
      a_ascii = 8'h41; a_pos = 6'h00;
      b_ascii = 8'h42; b_pos = 6'h11;
      a_valid = 1'b1;  b_valid = 1'b1;
      g = 0;
      stray = 0;
      for (int c = 0; c < 40 && g < 4; c++) begin
         step();
         if (write_start) begin
            chk($sformatf("arb_src%0d", g), 32'({a_ready, b_ready}), (g % 2 == 0) ? 32'd2 : 32'd1);
            chk($sformatf("arb_ascii%0d", g), 32'(write_ascii_data), (g % 2 == 0) ? 32'h41 : 32'h42);
            chk($sformatf("arb_addr%0d", g), 32'(write_base_addr), (g % 2 == 0) ? 32'h000 : 32'h088);
            g++;
            if (g == 4) begin
               a_valid = 1'b0;
               b_valid = 1'b0;
            end
         end else if (a_ready || b_ready) stray++;
      end
      chk("arb_cnt", 32'(g), 32'd4);
      chk("arb_stray", 32'(stray), 32'd0);

      // automatic update after eight accepted characters, twice
      reset_on();
      a_valid = 1'b1;
      rec(18, 150, got);
      chk("auto_cnt", 32'(got), 32'd18);
      for (int i = 0; i < got; i++) begin
         chk($sformatf("auto_kind%0d", i), 32'(act_kind[i]), (i == 8 || i == 17) ? 32'd1 : 32'd0);
         if (act_kind[i] == 1) chk($sformatf("auto_uc%0d", i), 32'(act_uc[i]), 32'd0);
      end

      // clear and flush together while a write is outstanding
      wait_ws("cf_ws");
      flush = 1'b1;
      clear = 1'b1;
      step();
      flush = 1'b0;
      clear = 1'b0;
      rec(3, 30, got);
      chk("cf_cnt", 32'(got), 32'd3);
      chk("cf_a0", 32'({act_kind[0][0], act_uc[0]}), 32'b11);
      chk("cf_a1", 32'({act_kind[1][0], act_uc[1]}), 32'b10);
      chk("cf_a2", 32'(act_kind[2]), 32'd0);

      // power down requested while an update is in flight
      a_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      cnt = 0;
      for (int c = 0; c < 10 && cnt == 0; c++) begin
         step();
         if (update_start) cnt = 1;
      end
      chk("pd_upd", 32'(cnt), 32'd1);
      en = 1'b0;
      a_valid = 1'b1;
      disp_on_ready = 1'b1;
      cnt = 0;
      stray = 0;
      for (int c = 0; c < 10 && cnt == 0; c++) begin
         step();
         if (disp_off_start) cnt = 1;
         if (write_start || update_start) stray++;
      end
      chk("pd_off", 32'(cnt), 32'd1);
      chk("pd_stray", 32'(stray), 32'd0);
      step();
      chk("pd_offwait", 32'({disp_up, busy}), 32'b01);
      step();
      chk("pd_off_state", 32'(outv()), 32'd0);
      step();
      step();
      chk("pd_no_accept", 32'(outv()), 32'd0);

      // watchdog on a stuck write
      en = 1'b1;
      step();
      wait_ws("wd_ws");
      a_valid = 1'b0;
      write_ready = 1'b0;
      for (int c = 0; c < 14; c++) step();
      chk("wd_pre", 32'(err), 32'd0);
      step();
      chk("wd_set", 32'({err, disp_up, busy}), 32'b111);
      write_ready = 1'b1;
      step();
      chk("wd_exit", 32'({err, busy}), 32'b10);
      step();
      step();
      chk("wd_sticky", 32'(err), 32'd1);

      chk("one_start", 32'(multi), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
